// File: rtl/scan_chain_ctrl.sv
// Mux-scan chain controller: shifts a pattern in LSB first, runs functional
// capture cycles, shifts the response out and presents it as a parallel word.
module scan_chain_ctrl #(
  parameter int LEN        = 8,
  parameter int CAP_CYCLES = 1
) (
  input  logic           ck,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [LEN-1:0] si_word,
  input  logic           scan_out,
  output logic           sd,
  output logic           sp,
  output logic           scan_in,
  output logic           busy,
  output logic           done,
  output logic [LEN-1:0] so_word
);

  // One counter serves both the shift phases and the capture phase.
  localparam int CNT_MAX = (LEN > CAP_CYCLES) ? LEN : CAP_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] SHIFT_LAST = CW'(LEN - 1);
  localparam logic [CW-1:0] CAP_LAST   = CW'(CAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, CAPTURE, UNLOAD, FIN} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [LEN-1:0] pat_reg, pat_next;
  logic [LEN-1:0] word_reg, word_next;
  logic [LEN-1:0] so_word_reg, so_word_next;
  logic           sd_reg, sd_next;
  logic           sp_reg, sp_next;
  logic           scan_in_reg, scan_in_next;
  logic           busy_reg, busy_next;
  logic           done_reg, done_next;

  // Response bits enter at the top so the first bit out lands in bit 0.
  logic [LEN:0] unload_shift;
  assign unload_shift = {scan_out, word_reg};

  always_ff @(posedge ck) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      pat_reg     <= '0;
      word_reg    <= '0;
      so_word_reg <= '0;
      sd_reg      <= 1'b0;
      sp_reg      <= 1'b0;
      scan_in_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pat_reg     <= pat_next;
      word_reg    <= word_next;
      so_word_reg <= so_word_next;
      sd_reg      <= sd_next;
      sp_reg      <= sp_next;
      scan_in_reg <= scan_in_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  // Outputs are decoded for the cycle being entered, so each registered
  // output lines up with the state it belongs to.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    pat_next     = pat_reg;
    word_next    = word_reg;
    so_word_next = so_word_reg;
    sd_next      = 1'b0;
    sp_next      = 1'b0;
    scan_in_next = 1'b0;
    busy_next    = 1'b0;
    done_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          state_next   = LOAD;
          cnt_next     = '0;
          pat_next     = si_word >> 1;
          sd_next      = 1'b1;
          sp_next      = 1'b1;
          scan_in_next = si_word[0];
          busy_next    = 1'b1;
        end
      end
      LOAD: begin
        busy_next = 1'b1;
        sp_next   = 1'b1;
        if (cnt_reg == SHIFT_LAST) begin
          state_next = CAPTURE;
          cnt_next   = '0;
        end else begin
          cnt_next     = cnt_reg + CW'(1);
          sd_next      = 1'b1;
          scan_in_next = pat_reg[0];
          pat_next     = pat_reg >> 1;
        end
      end
      CAPTURE: begin
        busy_next = 1'b1;
        sp_next   = 1'b1;
        if (cnt_reg == CAP_LAST) begin
          state_next = UNLOAD;
          cnt_next   = '0;
          sd_next    = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      UNLOAD: begin
        busy_next = 1'b1;
        word_next = unload_shift[LEN:1];
        if (cnt_reg == SHIFT_LAST) begin
          state_next = FIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
          sd_next  = 1'b1;
          sp_next  = 1'b1;
        end
      end
      FIN: begin
        state_next   = IDLE;
        so_word_next = word_reg;
        done_next    = 1'b1;
        busy_next    = 1'b1;
      end
      default: state_next = IDLE;
    endcase

    if (abort && state_reg != IDLE) begin
      state_next   = IDLE;
      cnt_next     = '0;
      word_next    = word_reg;
      so_word_next = so_word_reg;
      sd_next      = 1'b0;
      sp_next      = 1'b0;
      scan_in_next = 1'b0;
      busy_next    = 1'b0;
      done_next    = 1'b0;
    end
  end

  assign sd      = sd_reg;
  assign sp      = sp_reg;
  assign scan_in = scan_in_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign so_word = so_word_reg;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: two instances (8-flop inverting chain, 1-flop
// tied-high chain) driven through load/capture/unload, abort and reset cases.
module tb_scan_chain_ctrl;

  localparam int A_LEN = 8;
  localparam int A_CAP = 1;
  localparam int B_LEN = 1;
  localparam int B_CAP = 4;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic rst;
  logic a_start, a_abort, a_scan_out, a_sd, a_sp, a_scan_in, a_busy, a_done;
  logic [A_LEN-1:0] a_si_word, a_so_word;
  logic b_start, b_abort, b_scan_out, b_sd, b_sp, b_scan_in, b_busy, b_done;
  logic [B_LEN-1:0] b_si_word, b_so_word;

  int checks = 0;
  int errors = 0;

  scan_chain_ctrl #(.LEN(A_LEN), .CAP_CYCLES(A_CAP)) dut_a (
    .ck(ck), .rst(rst), .start(a_start), .abort(a_abort), .si_word(a_si_word),
    .scan_out(a_scan_out), .sd(a_sd), .sp(a_sp), .scan_in(a_scan_in),
    .busy(a_busy), .done(a_done), .so_word(a_so_word)
  );

  scan_chain_ctrl #(.LEN(B_LEN), .CAP_CYCLES(B_CAP)) dut_b (
    .ck(ck), .rst(rst), .start(b_start), .abort(b_abort), .si_word(b_si_word),
    .scan_out(b_scan_out), .sd(b_sd), .sp(b_sp), .scan_in(b_scan_in),
    .busy(b_busy), .done(b_done), .so_word(b_so_word)
  );

  // External mux-scan chains: A has functional D0 = ~Q, B has D0 tied high.
  logic [A_LEN-1:0] chain_a = '0;
  logic             chain_b = 1'b0;
  always @(posedge ck) begin
    if (a_sp) chain_a <= a_sd ? {chain_a[A_LEN-2:0], a_scan_in} : ~chain_a;
    if (b_sp) chain_b <= b_sd ? b_scan_in : 1'b1;
  end
  assign a_scan_out = chain_a[A_LEN-1];
  assign b_scan_out = chain_b;

  // Response of chain A: the pattern is reloaded unchanged, each capture inverts it.
  function automatic logic [A_LEN-1:0] model_a(input logic [A_LEN-1:0] p);
    return (A_CAP % 2 == 1) ? ~p : p;
  endfunction

  task automatic test_reset();
    rst = 1'b1; a_start = 1'b1; b_start = 1'b1;
    repeat (3) @(negedge ck);
    checks++;
    if ({a_sd, a_sp, a_scan_in, a_busy, a_done} !== 5'b0)
      begin errors++; $display("FAIL reset_a_outputs: got %b expected 00000", {a_sd, a_sp, a_scan_in, a_busy, a_done}); end
    checks++;
    if (a_so_word !== '0) begin errors++; $display("FAIL reset_a_so_word: got %h expected 00", a_so_word); end
    checks++;
    if ({b_sd, b_sp, b_scan_in, b_busy, b_done, b_so_word} !== 6'b0)
      begin errors++; $display("FAIL reset_b: got %b expected 000000", {b_sd, b_sp, b_scan_in, b_busy, b_done, b_so_word}); end
    rst = 1'b0; a_start = 1'b0; b_start = 1'b0;
    @(negedge ck);
  endtask

  task automatic test_sequences();
    logic [A_LEN-1:0] pats [8];
    logic [A_LEN-1:0] p, exp_so, prev_so;
    logic [4:0] exp_o;
    int done_at;
    pats[0] = 8'hA5; pats[1] = 8'h01;
    for (int i = 2; i < 8; i++) pats[i] = 8'($urandom);
    prev_so = '0;
    for (int n = 0; n < 8; n++) begin
      p = pats[n];
      exp_so = model_a(p);
      a_si_word = p; a_start = 1'b1;
      @(negedge ck);
      a_start = 1'b0;
      done_at = -1;
      for (int j = 0; j <= 2*A_LEN + A_CAP + 2; j++) begin
        if (j < A_LEN)                       exp_o = {1'b1, 1'b1, p[j], 1'b1, 1'b0};
        else if (j < A_LEN + A_CAP)          exp_o = 5'b01010;
        else if (j < 2*A_LEN + A_CAP)        exp_o = 5'b11010;
        else if (j == 2*A_LEN + A_CAP)       exp_o = 5'b00010;
        else if (j == 2*A_LEN + A_CAP + 1)   exp_o = 5'b00011;
        else                                 exp_o = 5'b00000;
        checks++;
        if ({a_sd, a_sp, a_scan_in, a_busy, a_done} !== exp_o)
          begin errors++; $display("FAIL seq_outputs: seq %0d cycle %0d got sd/sp/si/busy/done=%b expected %b", n, j, {a_sd, a_sp, a_scan_in, a_busy, a_done}, exp_o); end
        checks++;
        if (a_so_word !== ((j < 2*A_LEN + A_CAP + 1) ? prev_so : exp_so))
          begin errors++; $display("FAIL seq_so_word: seq %0d cycle %0d got %h expected %h", n, j, a_so_word, (j < 2*A_LEN + A_CAP + 1) ? prev_so : exp_so); end
        if (a_done === 1'b1 && done_at < 0) done_at = j;
        a_si_word = 8'($urandom);
        @(negedge ck);
      end
      checks++;
      if (done_at != 2*A_LEN + A_CAP + 1)
        begin errors++; $display("FAIL seq_latency: seq %0d got %0d expected %0d", n, done_at, 2*A_LEN + A_CAP + 1); end
      $display("seq %0d: si_word=%h so_word=%h done_latency=%0d", n, p, a_so_word, done_at);
      prev_so = exp_so;
    end
  endtask

  task automatic test_start_abort_idle();
    a_start = 1'b1; a_abort = 1'b1; a_si_word = 8'($urandom);
    @(negedge ck);
    a_start = 1'b0; a_abort = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({a_sd, a_sp, a_scan_in, a_busy, a_done} !== 5'b0)
        begin errors++; $display("FAIL start_abort_idle: cycle %0d got %b expected 00000", k, {a_sd, a_sp, a_scan_in, a_busy, a_done}); end
      @(negedge ck);
    end
    $display("start+abort in idle: sequence not started");
  endtask

  task automatic test_abort();
    int k, dones;
    a_si_word = 8'hA5; a_start = 1'b1;
    @(negedge ck);
    a_start = 1'b0;
    k = 0;
    while (a_done !== 1'b1 && k < 40) begin @(negedge ck); k++; end
    checks++;
    if (a_so_word !== 8'h5A) begin errors++; $display("FAIL abort_prior_word: got %h expected 5a", a_so_word); end
    @(negedge ck);
    a_si_word = 8'hC3; a_start = 1'b1;
    @(negedge ck);
    a_start = 1'b0;
    repeat (A_LEN + A_CAP + 3) @(negedge ck);
    a_abort = 1'b1;
    @(negedge ck);
    a_abort = 1'b0;
    checks++;
    if ({a_sd, a_sp, a_scan_in, a_busy, a_done} !== 5'b0)
      begin errors++; $display("FAIL abort_idle: got %b expected 00000", {a_sd, a_sp, a_scan_in, a_busy, a_done}); end
    dones = 0;
    for (int n = 0; n < 25; n++) begin
      if (a_done === 1'b1) dones++;
      @(negedge ck);
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", dones); end
    checks++;
    if (a_so_word !== 8'h5A) begin errors++; $display("FAIL abort_so_word: got %h expected 5a", a_so_word); end
    $display("abort at unload cycle 3: so_word=%h done_pulses=%0d", a_so_word, dones);
  endtask

  task automatic test_back_to_back();
    logic [A_LEN-1:0] w [4];
    int k;
    for (int i = 0; i < 4; i++) w[i] = 8'($urandom);
    a_si_word = w[0]; a_start = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge ck);
      checks++;
      if (a_done !== ((n % 19) == 0))
        begin errors++; $display("FAIL b2b_done: cycle %0d got %b expected %b", n, a_done, (n % 19) == 0); end
      checks++;
      if (a_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: cycle %0d got %b expected 1", n, a_busy); end
      if (n % 19 == 0) begin
        checks++;
        if (a_so_word !== model_a(w[n/19 - 1]))
          begin errors++; $display("FAIL b2b_so_word: cycle %0d got %h expected %h", n, a_so_word, model_a(w[n/19 - 1])); end
        $display("b2b done at cycle %0d: so_word=%h", n, a_so_word);
      end
      if (n % 19 == 1 && n/19 + 1 < 4) a_si_word = w[n/19 + 1];
    end
    a_start = 1'b0;
    k = 0;
    while (a_done !== 1'b1 && k < 30) begin @(negedge ck); k++; end
    checks++;
    if (k != 16) begin errors++; $display("FAIL b2b_drain_latency: got %0d expected 16", k); end
    checks++;
    if (a_so_word !== model_a(w[3])) begin errors++; $display("FAIL b2b_drain_word: got %h expected %h", a_so_word, model_a(w[3])); end
    @(negedge ck);
  endtask

  task automatic test_rst_mid();
    int k;
    a_si_word = 8'h3C; a_start = 1'b1;
    @(negedge ck);
    a_start = 1'b0;
    repeat (A_LEN) @(negedge ck);
    checks++;
    if ({a_sd, a_sp, a_scan_in, a_busy, a_done} !== 5'b01010)
      begin errors++; $display("FAIL rst_mid_in_capture: got %b expected 01010", {a_sd, a_sp, a_scan_in, a_busy, a_done}); end
    rst = 1'b1;
    @(negedge ck);
    rst = 1'b0;
    checks++;
    if ({a_sd, a_sp, a_scan_in, a_busy, a_done, a_so_word} !== 13'b0)
      begin errors++; $display("FAIL rst_mid_outputs: got %b/%h expected 00000/00", {a_sd, a_sp, a_scan_in, a_busy, a_done}, a_so_word); end
    a_si_word = 8'hA5; a_start = 1'b1;
    @(negedge ck);
    a_start = 1'b0;
    checks++;
    if ({a_sd, a_sp, a_scan_in, a_busy, a_done} !== 5'b11110)
      begin errors++; $display("FAIL rst_mid_restart: got %b expected 11110", {a_sd, a_sp, a_scan_in, a_busy, a_done}); end
    k = 0;
    while (a_done !== 1'b1 && k < 40) begin @(negedge ck); k++; end
    checks++;
    if (k != 2*A_LEN + A_CAP + 1) begin errors++; $display("FAIL rst_mid_latency: got %0d expected %0d", k, 2*A_LEN + A_CAP + 1); end
    checks++;
    if (a_so_word !== 8'h5A) begin errors++; $display("FAIL rst_mid_word: got %h expected 5a", a_so_word); end
    $display("reset in capture then restart: so_word=%h latency=%0d", a_so_word, k);
    @(negedge ck);
  endtask

  task automatic test_len1();
    logic [4:0] exp_o;
    logic       si;
    int done_at;
    for (int n = 0; n < 2; n++) begin
      si = (n == 1);
      b_si_word = si; b_start = 1'b1;
      @(negedge ck);
      b_start = 1'b0;
      done_at = -1;
      for (int j = 0; j <= 2*B_LEN + B_CAP + 2; j++) begin
        if (j < B_LEN)                       exp_o = {1'b1, 1'b1, si, 1'b1, 1'b0};
        else if (j < B_LEN + B_CAP)          exp_o = 5'b01010;
        else if (j < 2*B_LEN + B_CAP)        exp_o = 5'b11010;
        else if (j == 2*B_LEN + B_CAP)       exp_o = 5'b00010;
        else if (j == 2*B_LEN + B_CAP + 1)   exp_o = 5'b00011;
        else                                 exp_o = 5'b00000;
        checks++;
        if ({b_sd, b_sp, b_scan_in, b_busy, b_done} !== exp_o)
          begin errors++; $display("FAIL len1_outputs: run %0d cycle %0d got %b expected %b", n, j, {b_sd, b_sp, b_scan_in, b_busy, b_done}, exp_o); end
        if (b_done === 1'b1 && done_at < 0) done_at = j;
        @(negedge ck);
      end
      checks++;
      if (done_at != 7) begin errors++; $display("FAIL len1_latency: run %0d got %0d expected 7", n, done_at); end
      checks++;
      if (b_so_word !== 1'b1) begin errors++; $display("FAIL len1_so_word: run %0d got %b expected 1", n, b_so_word); end
      $display("len1 run %0d: si_word=%b so_word=%b latency=%0d", n, si, b_so_word, done_at);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_abort = 1'b0; a_si_word = '0;
    b_start = 1'b0; b_abort = 1'b0; b_si_word = '0;
    test_reset();
    test_sequences();
    test_start_abort_idle();
    test_abort();
    test_back_to_back();
    test_rst_mid();
    test_len1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_chain_ctrl.md
SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

Interface
REQ-001 SHALL have parameter LEN, default 8, meaning mux-scan chain length in flops; legal range 1..32.
REQ-002 SHALL have parameter CAP_CYCLES, default 1, meaning functional capture cycles per test; legal range 1..4.
REQ-003 SHALL have port CK  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port RST  input  1  reset; one clock, reset synchronous and active-high.
REQ-005 SHALL have port START  input  1  request a load/capture/unload sequence.
REQ-006 SHALL have port ABORT  input  1  terminate any sequence immediately.
REQ-007 SHALL have port SI_WORD  input  LEN  pattern to shift into the chain.
REQ-008 SHALL have port SCAN_OUT  input  1  Q of the last chain flop.
REQ-009 SHALL have port SD  output  1  chain scan select (1 = D1/scan path, 0 = D0/functional path).
REQ-010 SHALL have port SP  output  1  chain clock enable.
REQ-011 SHALL have port SCAN_IN  output  1  serial data into D1 of the first chain flop.
REQ-012 SHALL have port BUSY  output  1  high from START acceptance until DONE completes.
REQ-013 SHALL have port DONE  output  1  single-cycle completion pulse.
REQ-014 SHALL have port SO_WORD  output  LEN  captured response word.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, CAPTURE, UNLOAD, FIN; all outputs registered.
REQ-016 SHALL accept START only in IDLE with ABORT low: latch SI_WORD, clear shift counter, enter LOAD next cycle.
REQ-017 SHALL ignore START in any state other than IDLE; SI_WORD changes after acceptance SHALL have no effect.
REQ-018 SHALL in LOAD drive SD=1, SP=1, SCAN_IN = latched bit k in LOAD cycle k (k=0..LEN-1, LSB first), exactly LEN cycles, then enter CAPTURE.
REQ-019 SHALL in CAPTURE drive SD=0, SP=1, SCAN_IN=0 for exactly CAP_CYCLES cycles, then enter UNLOAD.
REQ-020 SHALL in UNLOAD drive SD=1, SP=1, SCAN_IN=0 for exactly LEN cycles, sampling SCAN_OUT into internal bit k on the edge ending UNLOAD cycle k.
REQ-021 SHALL in FIN drive SP=0, SD=0, copy the internal word to SO_WORD, assert DONE for one cycle, then return to IDLE.
REQ-022 SHALL hold SO_WORD unchanged between FIN cycles, including across aborted sequences.
REQ-023 SHALL drive SP=0, SD=0, SCAN_IN=0, BUSY=0 in IDLE.
REQ-024 SHALL give START-accept-edge to DONE-high latency of exactly 2*LEN+CAP_CYCLES+1 cycles; BUSY high for that whole span including the DONE cycle.
REQ-025 SHALL on ABORT high in any non-IDLE state go to IDLE on the next edge with SP=0, no DONE, SO_WORD unchanged.
REQ-026 SHALL treat START and ABORT both high in IDLE as ABORT: sequence not started.
REQ-027 SHALL accept a new START in the cycle after FIN (IDLE), giving back-to-back sequences with one idle cycle.
REQ-028 SHALL size the shift counter to hold LEN-1 without wrap; LEN=1 SHALL yield one LOAD and one UNLOAD cycle.

Reset
REQ-029 SHALL on RST high at an edge force IDLE, SD=0, SP=0, SCAN_IN=0, BUSY=0, DONE=0, SO_WORD=0, counters=0, overriding START and ABORT.
REQ-030 SHALL on RST mid-sequence abandon it with no DONE; the chain contents are undefined and not restored.

Verification
REQ-031 SHALL check: LEN=8, CAP=1, chain model = 8 mux-scan flops with functional D0 = ~Q, SI_WORD=0xA5 -> SO_WORD=0x5A, DONE exactly 18 cycles after accept.
REQ-032 SHALL check: SCAN_IN sequence during LOAD for SI_WORD=0x01 -> 1,0,0,0,0,0,0,0; SD=1/0/1 over LOAD/CAPTURE/UNLOAD.
REQ-033 SHALL check: ABORT at UNLOAD cycle 3 -> IDLE next cycle, no DONE, SO_WORD keeps prior 0x5A.
REQ-034 SHALL check: START held high continuously -> sequences start every 19 cycles, each with one DONE pulse.
REQ-035 SHALL check: RST during CAPTURE -> next cycle all outputs 0, SO_WORD=0, START next cycle accepted normally.
REQ-036 SHALL check: LEN=1, CAP=4, D0 tied 1, SI_WORD=0 -> SO_WORD=1, DONE 7 cycles after accept.
